// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall / taken-branch flush controller for a 5-stage MIPS pipeline.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush cycle counters.
//
// state | meaning
// RUN   | normal flow; resolves branch (priority) or load-use hazard
// STALL | holding PC and IF/ID while bubbles enter ID/EX
// FLUSH | squashing wrong-path instructions in IF/ID and ID/EX
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] Instr_ifid,
  input  logic        memread_idex,
  input  logic [4:0]  rt_idex,
  input  logic        branch_taken_ex,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  state,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hazard;
  logic       pc_w, ifid_w, ifid_f, idex_f;
  logic [4:0] rs_ifid, rt_ifid;
  logic       unused_instr_bits;

  assign rs_ifid           = Instr_ifid[25:21];
  assign rt_ifid           = Instr_ifid[20:16];
  assign unused_instr_bits = ^{Instr_ifid[31:26], Instr_ifid[15:0]};

  assign hazard = memread_idex && (rt_idex != 5'd0) &&
                  ((rt_idex == rs_ifid) || (rt_idex == rt_ifid));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    ifid_f  = 1'b0;
    idex_f  = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_taken_ex) begin
          ifid_f = 1'b1;
          idex_f = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (hazard) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_f = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = STALL;
            cnt_d   = STALL_RELOAD;
          end
        end
      end
      STALL: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        idex_f = 1'b1;
        // A zero count can only come from a corrupted state; fall back to RUN.
        if (cnt_q <= 3'd1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      FLUSH: begin
        ifid_f = 1'b1;
        idex_f = 1'b1;
        if (cnt_q <= 3'd1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Reset forces hold-and-bubble on the buffers regardless of FSM contents.
  assign pc_write   = RST_N & pc_w;
  assign ifid_write = RST_N & ifid_w;
  assign ifid_flush = ~RST_N | ifid_f;
  assign idex_flush = ~RST_N | idex_f;
  assign state      = RST_N ? state_q : RUN;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!pc_write && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = 32'd0;
  assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: default-parameter DUT (a) and LOAD_STALL_CYCLES=3/FLUSH_CYCLES=2 DUT (b)
// share stimulus; each row carries hand-computed outputs {pc,ifw,iff,idf,state} for both.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] R = 6'b110000;  // RUN, pass-through
  localparam logic [5:0] H = 6'b000100;  // RUN, load-use hazard
  localparam logic [5:0] S = 6'b000101;  // STALL
  localparam logic [5:0] B = 6'b111100;  // RUN, taken branch
  localparam logic [5:0] F = 6'b111110;  // FLUSH
  localparam logic [5:0] X = 6'b001100;  // held in reset

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       mr;
    logic [4:0] rtx;
    logic       br;
    logic [5:0] ea;
    logic [5:0] eb;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] Instr_ifid;
  logic        memread_idex;
  logic [4:0]  rt_idex;
  logic        branch_taken_ex;

  logic        pc_a, ifw_a, iff_a, idf_a, pc_b, ifw_b, iff_b, idf_b;
  logic [1:0]  st_a, st_b;
  logic [31:0] sc_a, fc_a, sc_b, fc_b;

  vec_t vecs[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl dut_a (
    .CLK(CLK), .RST_N(RST_N), .Instr_ifid(Instr_ifid), .memread_idex(memread_idex),
    .rt_idex(rt_idex), .branch_taken_ex(branch_taken_ex),
    .pc_write(pc_a), .ifid_write(ifw_a), .ifid_flush(iff_a), .idex_flush(idf_a),
    .state(st_a), .stall_count(sc_a), .flush_count(fc_a));

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .Instr_ifid(Instr_ifid), .memread_idex(memread_idex),
    .rt_idex(rt_idex), .branch_taken_ex(branch_taken_ex),
    .pc_write(pc_b), .ifid_write(ifw_b), .ifid_flush(iff_b), .idex_flush(idf_b),
    .state(st_b), .stall_count(sc_b), .flush_count(fc_b));

  task automatic add(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                     input logic mr, input logic [4:0] rtx, input logic br,
                     input logic [5:0] ea, input logic [5:0] eb);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.mr = mr; v.rtx = rtx; v.br = br;
    v.ea = ea; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL row%0d %s got %0h want %0h", row, name, got, want);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    vec_t v;
    int row = 0;
    logic [31:0] esc_a = 0, efc_a = 0, esc_b = 0, efc_b = 0;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        v = sb.pop_front();
        row++;
        if (!v.rst) begin
          esc_a = 0; efc_a = 0; esc_b = 0; efc_b = 0;
        end
        chk("a_outputs", row, {26'd0, pc_a, ifw_a, iff_a, idf_a, st_a}, {26'd0, v.ea});
        chk("b_outputs", row, {26'd0, pc_b, ifw_b, iff_b, idf_b, st_b}, {26'd0, v.eb});
        chk("a_stall_count", row, sc_a, esc_a);
        chk("a_flush_count", row, fc_a, efc_a);
        chk("b_stall_count", row, sc_b, esc_b);
        chk("b_flush_count", row, fc_b, efc_b);
`ifdef HAZARD_STATS_EN
        if (v.rst) begin
          if (!v.ea[5]) esc_a++;
          if (v.ea[3])  efc_a++;
          if (!v.eb[5]) esc_b++;
          if (v.eb[3])  efc_b++;
        end
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0; Instr_ifid = '0; memread_idex = 1'b0; rt_idex = '0; branch_taken_ex = 1'b0;

    add(0, 0, 0, 0, 0, 0, X, X);
    add(0, 0, 0, 0, 0, 0, X, X);
    add(0, 0, 0, 0, 0, 0, X, X);
    add(1, 0, 0, 0, 0, 0, R, R);
    add(1, 3, 4, 0, 3, 0, R, R);  // rs match but not a load
    add(1, 8, 2, 1, 8, 0, H, H);  // load-use on rs
    add(1, 8, 2, 0, 8, 0, R, S);
    add(1, 0, 0, 0, 0, 0, R, S);
    add(1, 0, 0, 0, 0, 0, R, R);
    add(1, 0, 0, 1, 0, 0, R, R);  // load to $zero never stalls
    add(1, 1, 9, 1, 9, 0, H, H);  // load-use on rt
    add(1, 1, 9, 0, 0, 0, R, S);
    add(1, 1, 9, 0, 0, 0, R, S);
    add(1, 0, 0, 0, 0, 0, R, R);
    add(1, 0, 0, 0, 0, 1, B, B);
    add(1, 0, 0, 0, 0, 1, B, F);  // branch pulse inside FLUSH ignored by b
    add(1, 0, 0, 0, 0, 0, R, R);
    add(1, 5, 6, 1, 5, 1, B, B);  // branch beats hazard
    add(1, 5, 6, 0, 0, 0, R, F);
    add(1, 0, 0, 0, 0, 0, R, R);
    add(1, 7, 3, 1, 3, 0, H, H);
    add(1, 0, 0, 0, 0, 0, R, S);
    add(1, 0, 0, 0, 0, 0, R, S);
    add(1, 4, 7, 1, 4, 0, H, H);  // new load right after STALL
    add(1, 0, 0, 0, 0, 0, R, S);
    add(0, 0, 0, 0, 0, 0, X, X);  // reset in 2nd stall cycle
    add(0, 0, 0, 0, 0, 0, X, X);
    add(1, 0, 0, 0, 0, 0, R, R);
    add(1, 0, 0, 0, 0, 1, B, B);
    add(0, 0, 0, 0, 0, 0, X, X);  // reset mid-flush
    add(1, 0, 0, 0, 0, 0, R, R);
    add(1, 0, 0, 0, 0, 1, B, B);
    add(1, 0, 0, 0, 0, 0, R, F);
    add(1, 0, 0, 0, 0, 0, R, R);
    add(1, 2, 2, 1, 2, 0, H, H);
    add(1, 0, 0, 0, 0, 0, R, S);
    add(1, 0, 0, 0, 0, 0, R, S);
    add(1, 0, 0, 0, 0, 0, R, R);

    foreach (vecs[i]) begin
      @(posedge CLK);
      #1;
      RST_N = vecs[i].rst;
      if (!vecs[i].rst) begin
        Instr_ifid      = $urandom;
        memread_idex    = 1'($urandom_range(1));
        rt_idex         = 5'($urandom_range(31));
        branch_taken_ex = 1'($urandom_range(1));
      end else begin
        Instr_ifid      = {6'h23, vecs[i].rs, vecs[i].rt, 16'h1234};
        memread_idex    = vecs[i].mr;
        rt_idex         = vecs[i].rtx;
        branch_taken_ex = vecs[i].br;
      end
      sb.push_back(vecs[i]);
    end

    repeat (3) @(posedge CLK);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard controller for the 5-stage MIPS pipeline: inspects the instruction held in the IF/ID buffer and the load in the ID/EX buffer, and drives the hold/flush controls back into the PC, IF/ID and ID/EX buffers. It is the control-side counterpart of the pipeline buffers, deciding each cycle whether they capture, hold, or bubble. It resolves load-use stalls, with a configurable memory latency, and taken-branch flushes using a small FSM with a down-counter.

## Interface
Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
- FLUSH_CYCLES, 1, cycles IF/ID and ID/EX are flushed after a taken branch (1..7)

Ports:
- CLK  in  1  single clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- Instr_ifid  in  32  instruction in IF/ID; rs=[25:21], rt=[20:16]
- memread_idex  in  1  instruction in ID/EX is a load
- rt_idex  in  5  load destination register in ID/EX
- branch_taken_ex  in  1  branch resolved taken in EX this cycle
- pc_write  out  1  1 = PC updates
- ifid_write  out  1  1 = IF/ID captures
- ifid_flush  out  1  1 = IF/ID loads zero (nop)
- idex_flush  out  1  1 = ID/EX loads bubble (all controls 0)
- state  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH
- stall_count  out  32  cycles with pc_write=0 (see Configuration)
- flush_count  out  32  cycles with ifid_flush=1 (see Configuration)

## Operation
- hazard = memread_idex & (rt_idex != 0) & (rt_idex == rs | rt_idex == rt); combinational.
- 3-bit down-counter cnt; state register. Both are cleared by reset.
- RUN:
  - branch_taken_ex=1 (priority over hazard): pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1.
    - Next state is FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
  - else hazard=1: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1.
    - Next state is STALL with cnt=LOAD_STALL_CYCLES-1 if LOAD_STALL_CYCLES>1, else RUN.
  - else: pc_write=1, ifid_write=1, flushes 0.
- STALL: pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1.
  - cnt decrements; when cnt==1, next state is RUN.
  - branch_taken_ex and hazard are ignored (EX holds a bubble).
- FLUSH: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1.
  - cnt decrements; when cnt==1, next state is RUN.
  - branch_taken_ex is ignored (wrong-path instructions).
- Flush overrides write: the buffers apply flush whenever it is 1.

## Timing
- Outputs are combinational from state plus inputs and are valid in the same cycle as the hazard or branch. State updates on the rising edge of CLK.
- While RST_N=0, outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, state=0. Counters read 0.
- The first edge after RST_N rises evaluates in RUN.
- Load-use hazard costs exactly LOAD_STALL_CYCLES cycles with pc_write=0. Taken branch costs exactly FLUSH_CYCLES cycles with ifid_flush=1.
- Reset asserted mid-STALL or mid-FLUSH aborts immediately: state goes to RUN and cnt to 0 with no residual cycles.
- Branch and hazard in the same RUN cycle: branch wins and no stall is recorded.
- A hazard present in the first RUN cycle after STALL (a new load) starts a new stall.

## Configuration
- HAZARD_STATS_EN defined: stall_count and flush_count are 32-bit counters.
  - stall_count increments on each edge where pc_write=0 and RST_N=1.
  - flush_count increments on each edge where ifid_flush=1 and RST_N=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- HAZARD_STATS_EN undefined: both ports are present and tied to 0, and no counter logic is synthesized.

## Test plan
- Reset: hold RST_N=0 for 3 cycles with random inputs -> pc_write=0, ifid_write=0, both flushes=1, state=0. On release with no hazard -> pc_write=1, ifid_write=1, flushes=0.
- Load-use (defaults): memread_idex=1, rt_idex=8, Instr_ifid rs=8 -> exactly 1 cycle of pc_write=0 and idex_flush=1, then RUN. With rt_idex=0 -> no stall.
- LOAD_STALL_CYCLES=3: hazard on rt match (rt=9, rt_idex=9) -> pc_write=0 for exactly 3 cycles, state sequence 0,1,1,0.
- FLUSH_CYCLES=2: branch_taken_ex=1 for one cycle -> ifid_flush=1 and idex_flush=1 for 2 cycles, pc_write=1 throughout. A branch_taken_ex pulse during FLUSH is ignored.
- Simultaneous branch and hazard -> flush behaviour only. With HAZARD_STATS_EN, stall_count is unchanged and flush_count increases by FLUSH_CYCLES.
- RST_N dropped during the 2nd cycle of a 3-cycle stall -> outputs immediately take reset values. After release the controller is in state 0 and counters read 0.
